// File: rtl/onehot_decoder_reg.sv
// Registered N-to-M one-hot decoder with level, pulse and latch modes,
// selectable output polarity and out-of-range flagging. One cycle request-to-output latency.
module onehot_decoder_reg #(
  parameter int SEL_W      = 3,
  parameter int NUM_OUT    = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [1:0]         mode_i,
  input  logic               clear_i,
  output logic [NUM_OUT-1:0] dec_o,
  output logic               valid_o,
  output logic               oor_o
);

  // Handshake: valid_i is a strobe with no back-pressure. A request is taken on
  // any rising edge where valid_i & en_i are high, clear_i is low and the mode is
  // unchanged; valid_o / oor_o are single-cycle responses one edge later.

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_PULSE = 2'b01,
    MODE_LATCH = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

  logic [NUM_OUT-1:0] onehot_q, onehot_d;
  mode_e              mode_q;
  logic [SEL_W-1:0]   last_sel_q;
  logic               last_acc_q;
  logic               valid_q, oor_q;

  logic               mode_change;
  logic               acc;
  logic               in_range;
  logic               inr;
  logic               repeat_req;
  logic [NUM_OUT-1:0] sel_onehot;
  logic [NUM_OUT-1:0] grant;

  assign mode_change = (mode_i != mode_q);
  assign acc         = valid_i & en_i & ~clear_i & ~mode_change;
  assign in_range    = ({1'b0, sel_i} < NUM_OUT_W);
  assign inr         = acc & in_range;
  assign repeat_req  = last_acc_q & (last_sel_q == sel_i);

  // Decode at NUM_OUT width; out-of-range selects match no output bit.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (sel_i == SEL_W'(i)) sel_onehot[i] = 1'b1;
    end
  end

  assign grant = inr ? sel_onehot : '0;

  always_comb begin
    onehot_d = '0;
    if (clear_i || mode_change) begin
      onehot_d = '0;
    end else begin
      unique case (mode_e'(mode_i))
        MODE_PULSE: onehot_d = repeat_req ? '0 : grant;
        MODE_LATCH: onehot_d = inr ? grant : onehot_q;
        MODE_LEVEL,
        MODE_RSVD:  onehot_d = grant;
        default:    onehot_d = grant;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      onehot_q   <= '0;
      mode_q     <= MODE_LEVEL;
      last_sel_q <= '0;
      last_acc_q <= 1'b0;
      valid_q    <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      onehot_q   <= onehot_d;
      mode_q     <= mode_e'(mode_i);
      last_sel_q <= sel_i;
      last_acc_q <= inr;
      valid_q    <= inr;
      oor_q      <= acc & ~in_range;
    end
  end

  assign dec_o   = ACTIVE_LOW ? ~onehot_q : onehot_q;
  assign valid_o = valid_q;
  assign oor_o   = oor_q;

  onehot_inv: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(onehot_q));

endmodule
